// File: rtl/lsu_ctrl.sv
// Load/store control unit between execute stage and a word-only data memory.
// Handles alignment checks, load extension, and read-modify-write for sub-word stores.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_err;

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] w, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (f3[1:0] == 2'b10) begin
            r = d;
        end else if (f3[1:0] == 2'b01) begin
            if (a[1]) r[31:16] = d[15:0];
            else      r[15:0]  = d[15:0];
        end else begin
            case (a)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end
        return r;
    endfunction

    always_comb begin
        logic illegal, misaligned;
        if (req_we) illegal = req_funct3[2] | (req_funct3 == 3'b011);
        else        illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
        misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                   | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
        req_err = illegal | misaligned;
    end

    assign req_ready  = rst_n & (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) & err_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_we     = (state_q == WR);
    assign mem_wd     = store_merge(f3_q, addr_q[1:0], word_q, wdata_q);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = RESP;
                        rdata_d = '0;
                    end else if (!req_we || req_funct3[1:0] != 2'b10) begin
                        state_d = RD;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            RD: begin
                word_d = mem_rd;
                if (we_q) begin
                    state_d = WR;
                end else begin
                    // Extract straight from mem_rd: same value word_q captures on this edge.
                    state_d = RESP;
                    rdata_d = load_ext(f3_q, addr_q[1:0], mem_rd);
                end
            end
            WR: begin
                state_d = RESP;
                rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a behavioural word memory.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] mem [0:63];
    logic        clr_en, pre_en;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    lsu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem_we ? 32'd0 : mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (clr_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wd;
        end else if (pre_en) begin
            mem[pre_idx] <= pre_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_idx  = idx;
        pre_data = data;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_wrc, input logic [31:0] exp_wd,
                         input logic hold);
        int  wrcnt;
        bit  done;
        wrcnt = 0;
        done  = 0;
        @(negedge clk);
        check({tag, ".ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            check({tag, ".ready_busy"}, {31'd0, req_ready}, 32'd0);
            if (mem_we) begin
                wrcnt++;
                check({tag, ".wr_cycle"}, c, exp_wrc);
                check({tag, ".mem_wd"}, mem_wd, exp_wd);
                check({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
            end
            if (resp_valid) begin
                done = 1;
                check({tag, ".latency"}, c, exp_lat);
                check({tag, ".rdata"}, resp_rdata, exp_rdata);
                check({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
            end
            if (hold && !done) begin
                req_valid  = 1'b1;
                req_we     = 1'b1;
                req_funct3 = 3'b010;
                req_addr   = 32'h20;
                req_wdata  = 32'hFFFFFFFF;
            end else begin
                req_valid  = 1'b0;
            end
        end
        if (!done) check({tag, ".timeout"}, 32'd0, 32'd1);
        check({tag, ".wr_count"}, wrcnt, (exp_wrc != 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        pre_en     = 1'b0;
        pre_idx    = '0;
        pre_data   = 32'd0;
        clr_en     = 1'b1;
        #1;
        check("rst.ready", {31'd0, req_ready}, 32'd0);
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.mem_we", {31'd0, mem_we}, 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.mem_wd", mem_wd, 32'd0);
        check("rst.rdata", resp_rdata, 32'd0);
        repeat (3) @(negedge clk);
        clr_en = 1'b0;
        rst_n  = 1'b1;
        preload(6'd4, 32'h8899AABB);

        issue("lb13",  1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFFFF88, 1'b0, 2, 0, 32'd0, 1'b0);
        issue("lbu12", 1'b0, 3'b100, 32'h12, 32'd0, 32'h00000099, 1'b0, 2, 0, 32'd0, 1'b0);
        issue("lh12",  1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFF8899, 1'b0, 2, 0, 32'd0, 1'b0);
        issue("lhu10", 1'b0, 3'b101, 32'h10, 32'd0, 32'h0000AABB, 1'b0, 2, 0, 32'd0, 1'b0);
        issue("lw10",  1'b0, 3'b010, 32'h10, 32'd0, 32'h8899AABB, 1'b0, 2, 0, 32'd0, 1'b0);

        issue("sb11",  1'b1, 3'b000, 32'h11, 32'h12345677, 32'd0, 1'b0, 3, 2, 32'h889977BB, 1'b0);
        issue("lw_sb", 1'b0, 3'b010, 32'h10, 32'd0, 32'h889977BB, 1'b0, 2, 0, 32'd0, 1'b0);

        preload(6'd4, 32'h8899AABB);
        issue("sh12",  1'b1, 3'b001, 32'h12, 32'h0000CAFE, 32'd0, 1'b0, 3, 2, 32'hCAFEAABB, 1'b1);
        issue("sw14",  1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1, 32'hDEADBEEF, 1'b1);
        check("mem10_after_sh", mem[4], 32'hCAFEAABB);
        check("mem14_after_sw", mem[5], 32'hDEADBEEF);
        check("mem20_busy_req", mem[8], 32'd0);

        issue("err_sh11", 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 32'd0, 1'b1, 1, 0, 32'd0, 1'b0);
        issue("err_lw12", 1'b0, 3'b010, 32'h12, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0, 1'b0);
        issue("err_f011", 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0, 1'b0);
        check("mem10_after_err", mem[4], 32'hCAFEAABB);

        // Reset during the RD cycle of a byte store.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h10;
        req_wdata  = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort.rd_no_we", {31'd0, mem_we}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort.mem_we", {31'd0, mem_we}, 32'd0);
        check("abort.ready", {31'd0, req_ready}, 32'd0);
        check("abort.mem_addr", mem_addr, 32'd0);
        check("abort.mem_wd", mem_wd, 32'd0);
        check("abort.rdata", resp_rdata, 32'd0);
        check("abort.err", {31'd0, resp_err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort.resp_valid", {31'd0, resp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("abort.no_resp_after", {31'd0, resp_valid}, 32'd0);
        check("abort.mem10", mem[4], 32'hCAFEAABB);

        issue("lw_post_rst", 1'b0, 3'b010, 32'h10, 32'd0, 32'hCAFEAABB, 1'b0, 2, 0, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control unit between the RISC-V core's execute stage and the word-wide data memory (`memo_Data`-style: combinational read, synchronous write, word-only, read data forced to zero while write enable is high). It accepts one load/store request at a time and performs address alignment checks. For loads it extracts bytes and halfwords with sign or zero extension. For byte and halfword stores it performs a read-modify-write, so the word-only memory never sees a partial-word write.

## Interface
- No parameters. Data and address width is fixed at 32; memory is word-addressed through byte address bits [31:2].
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present; sampled only when req_ready=1.
- req_ready  out  1  unit idle and able to accept a request; equals rst_n & (state==IDLE).
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; bits [7:0] are used for SB and [15:0] for SH.
- resp_valid  out  1  one-cycle pulse; the request has completed.
- resp_rdata  out  32  load result; 0 for stores and errors; held until the next response.
- resp_err  out  1  valid with resp_valid; set for a misaligned address or illegal funct3.
- mem_addr  out  32  word-aligned address to memory: {addr_q[31:2],2'b00}.
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data (combinational from mem_addr; zero while mem_we=1).

## Operation
- Accept: when req_valid & req_ready, register we, funct3, addr and wdata (addr_q etc.) and move to the first state per command.
- States: IDLE, RD, WR, RESP.
  - Load (LB/LH/LW/LBU/LHU): IDLE->RD->RESP->IDLE.
  - SW: IDLE->WR->RESP->IDLE.
  - SB/SH: IDLE->RD->WR->RESP->IDLE.
  - Error: IDLE->RESP->IDLE, with no memory access at all.
- Error conditions:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - Load funct3 in {011,110,111}.
  - Store funct3 other than {000,001,010}.
- RD: mem_we=0, mem_addr driven; mem_rd is captured into word_q at the end of the cycle.
- Load extraction from word_q (little-endian):
  - Byte lane is addr_q[1:0], halfword lane is addr_q[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - The result is registered into resp_rdata as the FSM enters RESP.
- WR: mem_we=1 for exactly one cycle.
  - mem_wd = wdata_q for SW.
  - For SB/SH, mem_wd = word_q with the addressed byte/halfword lane replaced by wdata_q[7:0]/[15:0]; all other lanes are unchanged.
- RESP: resp_valid=1 for one cycle.
  - resp_err per the error check.
  - resp_rdata = extracted data for loads, 0 otherwise.
- mem_we is 0 in every state except WR.
- mem_addr and mem_wd may hold stale values outside RD/WR, but must be 0 after reset until the first accept.
- No response backpressure; the core must take resp_valid when it pulses.

## Timing
- Accept edge = cycle 0.
- resp_valid asserts in cycle:
  - 1 for errors;
  - 2 for loads and SW;
  - 3 for SB/SH.
- req_ready=0 from cycle 1 until the cycle after RESP; it returns to 1 in the cycle following the resp_valid pulse.
- Minimum issue interval: 2 cycles for errors, 3 for loads and SW, 4 for SB/SH.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, mem_we 0, mem_addr 0, mem_wd 0.
  - While rst_n=0, req_ready=0.
- Reset mid-operation:
  - All state clears asynchronously and mem_we drops immediately.
  - An RMW interrupted in RD leaves memory untouched.
  - No resp_valid is produced for the aborted request.
- req_valid while busy is ignored; the request is not queued.
- Address wrap: the word address uses addr[31:2] unmodified; no carry into the next word ever occurs, because misaligned accesses are errors.

## Test plan
- Preload word 0x10 = 0x8899AABB.
  - LB 0x13 -> resp_rdata 0xFFFFFF88 at cycle 2.
  - LBU 0x12 -> 0x00000099.
  - LH 0x12 -> 0xFFFF8899.
  - LHU 0x10 -> 0x0000AABB.
  - LW 0x10 -> 0x8899AABB.
  - resp_err=0 on all five.
- SB 0x11 with wdata 0x12345677 -> exactly one RD then one WR cycle, mem_wd 0x889977BB, resp_valid at cycle 3; a following LW 0x10 returns 0x889977BB.
- SH 0x12 with wdata 0x0000CAFE, then SW 0x14 with 0xDEADBEEF -> word 0x10 = 0xCAFEAABB and word 0x14 = 0xDEADBEEF.
  - req_ready low throughout each operation.
  - A req_valid held during busy cycles is not accepted early.
- SH 0x11, LW 0x12, and a load with funct3=011 -> each gives resp_err=1 at cycle 1 with resp_rdata 0; mem_we never asserts; memory is unchanged.
- Assert rst_n=0 during the RD cycle of SB 0x10 -> no write occurs, no resp_valid, all outputs at reset values, word 0x10 unchanged.
- After reset is released, LW 0x10 completes normally at cycle 2.
